// File: rtl/mapa_pkg.sv
// Shared constants, state encoding and helpers for the map scan controller.
package mapa_pkg;

  localparam int NUM_MAPAS = 8;
  localparam int SEL_W     = 3;
  localparam int ROW_W     = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SCAN  = 2'd2,
    ST_SWAP  = 2'd3
  } scan_state_t;

  function automatic logic [NUM_MAPAS-1:0] col_onehot(input logic [SEL_W-1:0] k);
    return NUM_MAPAS'(1) << k;
  endfunction

endpackage

// File: rtl/mapa_dwell_timer.sv
// Dwell counter for the SCAN phase: counts 0..DWELL-1, wraps, and reports the
// terminal count both for the current cycle and for the value about to be loaded.
module mapa_dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o,
  output logic tc_next_o
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o      = (cnt_q == LAST);
  // Lets the controller register pulses that must coincide with the last SCAN cycle.
  assign tc_next_o = (cnt_d == LAST);

endmodule

// File: rtl/mapa_scan_ctrl.sv
// Column scan controller for a 7-row, 8-column multiplexed display: sequences
// sel, blanks between columns, latches row data and offers a per-frame swap window.
module mapa_scan_ctrl
  import mapa_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 hold,
  input  logic                 frame_req,
  input  logic [ROW_W-1:0]     mux_out,
  output logic [SEL_W-1:0]     sel,
  output logic [NUM_MAPAS-1:0] col_en,
  output logic [ROW_W-1:0]     row_out,
  output logic                 frame_done,
  output logic                 frame_ack,
  output logic                 busy,
  output scan_state_t          state_dbg
);

  localparam logic [SEL_W-1:0] LAST_COL = SEL_W'(NUM_MAPAS - 1);

  scan_state_t          state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [NUM_MAPAS-1:0] col_en_q, col_en_d;
  logic                 done_q, done_d;
  logic                 ack_q, ack_d;
  logic                 busy_q, busy_d;

  logic tmr_clr;
  logic tmr_inc;
  logic tc;
  logic tc_next;
  logic frozen;

  assign frozen = hold && (state_q != ST_IDLE);

  mapa_dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (tmr_clr),
    .inc_i     (tmr_inc),
    .tc_o      (tc),
    .tc_next_o (tc_next)
  );

  // Handshake: frame_req is a level held by the map-update logic; it is looked at
  // only on the last SCAN cycle of the last column. frame_ack pulses for the one
  // SWAP cycle (all columns dark); maps may change on the edge that ends it, and
  // the following BLANK captures the new contents for column 0.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    row_d   = row_q;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      sel_d   = '0;
      row_d   = '0;
      tmr_clr = 1'b1;
    end else if (!frozen) begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          sel_d   = '0;
          tmr_clr = 1'b1;
        end
        ST_BLANK: begin
          state_d = ST_SCAN;
          row_d   = mux_out;
          tmr_clr = 1'b1;
        end
        ST_SCAN: begin
          tmr_inc = 1'b1;
          if (tc) begin
            if (sel_q == LAST_COL) begin
              sel_d   = '0;
              state_d = frame_req ? ST_SWAP : ST_BLANK;
            end else begin
              sel_d   = sel_q + SEL_W'(1);
              state_d = ST_BLANK;
            end
          end
        end
        ST_SWAP: begin
          state_d = ST_BLANK;
          sel_d   = '0;
          tmr_clr = 1'b1;
        end
      endcase
    end
  end

  // Output registers are loaded from the next state, so every output settles on
  // the same edge as the state it describes. A frozen cycle reproduces the same values.
  always_comb begin
    col_en_d = (state_d == ST_SCAN) ? col_onehot(sel_d) : '0;
    done_d   = (state_d == ST_SCAN) && (sel_d == LAST_COL) && tc_next;
    ack_d    = (state_d == ST_SWAP);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      row_q    <= '0;
      col_en_q <= '0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      row_q    <= row_d;
      col_en_q <= col_en_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  assign sel       = sel_q;
  assign col_en    = col_en_q;
  assign row_out   = row_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;
  // Pulses are masked while frozen so each one is seen exactly once, after release.
  assign frame_done = done_q && !frozen;
  assign frame_ack  = ack_q && !frozen;

endmodule

// File: doc/mapa_scan_ctrl.md
# mapa_scan_ctrl

Scan controller that sequences the 8-way map multiplexer (`mux_64x8`) for a column-multiplexed 7-row display. It steps `sel` through columns 0..7 and inserts a blanking cycle before each column. It captures the mux output into a stable row register and drives a one-hot column enable. It also gives the map-update logic a safe per-frame window to swap map contents.

## Interface
- `DWELL`, default 4: SCAN cycles per column; legal range ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  run scanning; low forces IDLE.
- `hold`  in  1  freeze state, counter and outputs.
- `frame_req`  in  1  map-update logic requests a swap window; level, held until acked.
- `mux_out`  in  7  combinational output of `mux_64x8` for the current `sel`.
- `sel`  out  3  column select to `mux_64x8`.
- `col_en`  out  8  one-hot column drive, active-high; all-zero when blanked.
- `row_out`  out  7  registered row pattern for the active column.
- `frame_done`  out  1  one-cycle pulse, end of column 7.
- `frame_ack`  out  1  one-cycle pulse; maps may change on this edge.
- `busy`  out  1  high in any state except IDLE.

## Operation
- States: IDLE, BLANK, SCAN, SWAP.
- Reset: state=IDLE; `sel`=0, `col_en`=0, `row_out`=0, `frame_done`=0, `frame_ack`=0, `busy`=0, dwell count=0.
- IDLE: outputs at reset values. When `enable`=1, go to BLANK with `sel`=0.
- BLANK: lasts 1 cycle with `col_en`=0 and `sel`=k. On exit, `row_out`<=`mux_out` and the dwell count is cleared. Next state is SCAN.
- SCAN: `col_en`=1<<k and `row_out` is held. The dwell count advances to DWELL-1.
  - Last SCAN cycle of k<7: go to BLANK with `sel`=k+1.
  - Last SCAN cycle of k=7: `frame_done`=1 for that cycle only. `sel` wraps to 0. Go to SWAP if `frame_req`=1, else go to BLANK.
- SWAP: lasts 1 cycle with `col_en`=0 and `frame_ack`=1. Next state is BLANK with `sel`=0. The first column after SWAP captures the new map contents.
- `frame_req` is sampled only in the last SCAN cycle of column 7. A request raised mid-frame waits for the frame end.
- `hold`=1 freezes everything: state, `sel`, dwell count, `col_en` and `row_out` keep their values. `frame_done` and `frame_ack` are forced to 0 while held and fire once after release. `hold` is ignored in IDLE.
- Priority: `rst_n` > `enable`=0 > `hold` > normal sequencing.
- `enable` falling in any state: next cycle is IDLE with all outputs at reset values. An in-progress frame is abandoned and no ack is issued.
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronously). After release, scanning restarts at column 0 via BLANK.

## Timing
- From `enable` sampled high in IDLE: BLANK on the next cycle; `col_en`=0000_0001 one cycle later.
- Column period: 1+DWELL cycles. Frame: 8·(1+DWELL) cycles, plus 1 if SWAP occurs (40/41 cycles at DWELL=4).
- `row_out` changes only on a BLANK→SCAN edge, so it is never updated while `col_en`≠0. This guarantees no ghosting.
- `mux_out` must settle within one cycle of a `sel` change. `sel` is stable for the full BLANK cycle before capture.
- All outputs are registered.

## Structure
- Package `mapa_pkg`:
  - `NUM_MAPAS`=8, `SEL_W`=3, `ROW_W`=7.
  - State enum `scan_state_t`.
- Sub-module `mapa_dwell_timer`: parameterised DWELL counter with clear, enable (from `hold`) and terminal-count output.
- The controller does not instantiate `mux_64x8`; the parent connects `sel`/`mux_out`.

## Test plan
- Reset/idle:
  - Stimulus: `rst_n` low, then high with `enable`=0 for 10 cycles.
  - Required: all outputs 0 and `busy`=0 throughout.
- Full frame, DWELL=4:
  - Stimulus: maps 1000001, 1100011, 1110111, 1111001, 1111101, 1111110, 1111111, 0111111; `enable`=1.
  - Required: each `col_en` one-hot held 4 cycles, `row_out` matching map k, a 1-cycle blank between columns, `frame_done` at cycle 40, `sel` wraps to 0.
- Swap handshake:
  - Stimulus: raise `frame_req` during column 3.
  - Required: no ack until the frame end. `frame_ack` pulses for 1 cycle with `col_en`=0. After changing mapa0 to 0000000 on the ack, column 0 shows 0000000. Frame length is 41 cycles.
- Hold:
  - Stimulus: assert `hold` for 5 cycles in SCAN of column 5, then for 3 cycles in the last SCAN cycle of column 7.
  - Required: `col_en`=0010_0000 and `row_out`=1111110 are frozen. The frame stretches by 8 cycles. `frame_done` fires once, after the second release.
- Enable drop and reset mid-frame:
  - Stimulus: drop `enable` in column 2; re-enable; later pulse `rst_n` low asynchronously in column 6.
  - Required: IDLE with zeros on the next edge after the enable drop. Restart at BLANK column 0 after re-enable. Outputs zero immediately on the reset pulse, with no `frame_done`.
- DWELL=1 build:
  - Stimulus: run one frame with DWELL=1.
  - Required: frame length 16 cycles; `col_en` alternates with zero every cycle.
